// File: rtl/gates_truth_sequencer.sv
// Steps the 2-input Gates datapath through {A,B} = 00,01,10,11, samples Y once per
// vector into a truth table and compares it against a pattern latched at START.
module gates_truth_sequencer #(
  parameter int unsigned SETTLE_CYC = 4,
  parameter int unsigned CW         = 8
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       START,
  input  logic [3:0] EXPECTED,
  input  logic       Y_IN,
  output logic       A_OUT,
  output logic       B_OUT,
  output logic       BUSY,
  output logic       DONE,
  output logic [3:0] TT,
  output logic       PASS,
  output logic       FAIL,
  output logic [3:0] MISMATCH
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_REPORT
  } state_t;

  localparam logic [CW-1:0] LAST_CNT = CW'(SETTLE_CYC - 1);

  state_t      state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]  exp_q, exp_d;
  logic [3:0]  tt_q, tt_d;
  logic [1:0]  ab_q, ab_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        pass_q, pass_d;
  logic        fail_q, fail_d;
  logic [3:0]  mism_q, mism_d;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      exp_q   <= '0;
      tt_q    <= '0;
      ab_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      fail_q  <= 1'b0;
      mism_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      exp_q   <= exp_d;
      tt_q    <= tt_d;
      ab_q    <= ab_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
      mism_q  <= mism_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    exp_d   = exp_q;
    tt_d    = tt_q;
    ab_d    = ab_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    pass_d  = pass_q;
    fail_d  = fail_q;
    mism_d  = mism_q;

    unique case (state_q)
      S_IDLE: begin
        if (START) begin
          state_d = S_RUN;
          busy_d  = 1'b1;
          idx_d   = '0;
          ab_d    = '0;
          cnt_d   = '0;
          exp_d   = EXPECTED;
          tt_d    = '0;
          pass_d  = 1'b0;
          fail_d  = 1'b0;
          mism_d  = '0;
        end
      end
      S_RUN: begin
        if (cnt_q == LAST_CNT) begin
          tt_d[idx_q] = Y_IN;
          cnt_d       = '0;
          if (idx_q != 2'd3) begin
            idx_d = idx_q + 2'd1;
            ab_d  = idx_q + 2'd1;
          end else begin
            // Verdict uses tt_d so the bit captured on this same edge is included.
            state_d = S_REPORT;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            ab_d    = '0;
            idx_d   = '0;
            pass_d  = (tt_d == exp_q);
            fail_d  = (tt_d != exp_q);
            mism_d  = tt_d ^ exp_q;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_REPORT: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign A_OUT    = ab_q[1];
  assign B_OUT    = ab_q[0];
  assign BUSY     = busy_q;
  assign DONE     = done_q;
  assign TT       = tt_q;
  assign PASS     = pass_q;
  assign FAIL     = fail_q;
  assign MISMATCH = mism_q;

endmodule

// File: tb/tb_gates_truth_sequencer.sv
// Bench for gates_truth_sequencer: timeline-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized runs with Y noise.
module tb_gates_truth_sequencer;

  localparam int S = 4;

  logic       CLK = 1'b0;
  logic       RST;
  logic       START;
  logic [3:0] EXPECTED;
  logic       y_in, y1_in;
  logic       a_o, b_o, busy_o, done_o, pass_o, fail_o;
  logic [3:0] tt_o, mism_o;
  logic       a1_o, b1_o, busy1_o, done1_o, pass1_o, fail1_o;
  logic [3:0] tt1_o, mism1_o;

  // Gate truth tables indexed by {A,B}: AND, OR, XOR, NAND
  logic [3:0] gtt [4];
  int         gate_sel;
  logic       y_force_en, y_force_val;

  int n_checks = 0;
  int n_pass   = 0;
  bit cmp_en   = 1'b0;

  always #5 CLK = ~CLK;

  initial begin
    gtt[0] = 4'b1000;
    gtt[1] = 4'b1110;
    gtt[2] = 4'b0110;
    gtt[3] = 4'b0111;
  end

  assign y_in  = y_force_en ? y_force_val : gtt[gate_sel][{a_o, b_o}];
  assign y1_in = gtt[gate_sel][{a1_o, b1_o}];

  gates_truth_sequencer #(.SETTLE_CYC(S), .CW(8)) u_dut (
    .CLK(CLK), .RST(RST), .START(START), .EXPECTED(EXPECTED), .Y_IN(y_in),
    .A_OUT(a_o), .B_OUT(b_o), .BUSY(busy_o), .DONE(done_o), .TT(tt_o),
    .PASS(pass_o), .FAIL(fail_o), .MISMATCH(mism_o)
  );

  gates_truth_sequencer #(.SETTLE_CYC(1), .CW(2)) u_dut1 (
    .CLK(CLK), .RST(RST), .START(START), .EXPECTED(EXPECTED), .Y_IN(y1_in),
    .A_OUT(a1_o), .B_OUT(b1_o), .BUSY(busy1_o), .DONE(done1_o), .TT(tt1_o),
    .PASS(pass1_o), .FAIL(fail1_o), .MISMATCH(mism1_o)
  );

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Reference model: j counts edges since the accepted START; vector v occupies
  // edges v*S+1 .. (v+1)*S and is sampled on the last of them.
  bit         m_inrun;
  int         m_j;
  logic [1:0] m_ab;
  logic       m_busy, m_done, m_pass, m_fail;
  logic [3:0] m_tt, m_exp, m_mism;

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      m_inrun = 0; m_j = 0; m_ab = 0; m_busy = 0; m_done = 0;
      m_pass = 0; m_fail = 0; m_tt = 0; m_exp = 0; m_mism = 0;
    end else if (!m_inrun) begin
      m_done = 0;
      if (START) begin
        m_inrun = 1; m_j = 0; m_ab = 0; m_busy = 1; m_exp = EXPECTED;
        m_tt = 0; m_pass = 0; m_fail = 0; m_mism = 0;
      end
    end else begin
      m_j++;
      if (m_j <= 4 * S && m_j % S == 0) m_tt[m_j / S - 1] = y_in;
      if (m_j < 4 * S) begin
        m_ab = 2'(m_j / S);
      end else if (m_j == 4 * S) begin
        m_busy = 0; m_done = 1; m_ab = 0;
        m_pass = (m_tt == m_exp);
        m_fail = !m_pass;
        m_mism = m_tt ^ m_exp;
      end else begin
        m_done = 0;
        m_inrun = 0;
      end
    end
  end

  always @(negedge CLK) begin
    if (cmp_en) begin
      check("cycle", {a_o, b_o, busy_o, done_o, tt_o, pass_o, fail_o, mism_o, 2'b00},
                     {m_ab, m_busy, m_done, m_tt, m_pass, m_fail, m_mism, 2'b00});
      if (pass_o && fail_o) check("pass_fail_exclusive", 16'd1, 16'd0);
    end
  end

  task automatic step();
    @(posedge CLK);
    #2;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    do begin
      step();
      lat++;
    end while (!done_o && lat < 200);
    if (lat >= 200) check("done_timeout", 16'd0, 16'd1);
  endtask

  task automatic run(input int g, input logic [3:0] e, output int lat);
    gate_sel = g;
    EXPECTED = e;
    START = 1'b1;
    step();
    START = 1'b0;
    wait_done(lat);
  endtask

  int lat, ndone, at, gap;
  logic [3:0] ab1;

  initial begin
    RST = 1'b1; START = 1'b0; EXPECTED = '0; gate_sel = 0;
    y_force_en = 1'b0; y_force_val = 1'b0;
    #1 cmp_en = 1'b1;
    step(); step();
    check("reset_outputs", {a_o, b_o, busy_o, done_o, tt_o, pass_o, fail_o, mism_o, 2'b00}, 16'h0);
    RST = 1'b0;
    step();

    // AND against 1000
    run(0, 4'b1000, lat);
    check("and_latency", 16'(lat), 16'd16);
    check("and_tt", {12'h0, tt_o}, 16'b1000);
    check("and_pf", {14'h0, pass_o, fail_o}, 16'b10);
    check("and_mism", {12'h0, mism_o}, 16'h0);
    step();
    check("done_one_cycle", {15'h0, done_o}, 16'h0);
    check("hold_tt", {12'h0, tt_o}, 16'b1000);

    // XOR against wrong pattern, then rerun with right pattern
    run(2, 4'b1000, lat);
    check("xor_tt", {12'h0, tt_o}, 16'b0110);
    check("xor_pf", {14'h0, pass_o, fail_o}, 16'b01);
    check("xor_mism", {12'h0, mism_o}, 16'b1110);
    step();
    EXPECTED = 4'b0110; START = 1'b1;
    step();
    START = 1'b0;
    check("start_clears", {10'h0, pass_o, fail_o, mism_o}, 16'h0);
    wait_done(lat);
    check("xor_rerun_pass", {14'h0, pass_o, fail_o}, 16'b10);
    step();

    // SETTLE_CYC=1 instance with OR
    gate_sel = 1; EXPECTED = 4'b1110; START = 1'b1;
    step();
    START = 1'b0;
    for (int k = 0; k < 4; k++) begin
      ab1 = 4'({a1_o, b1_o});
      check("s1_vector", {12'h0, ab1}, 16'(k));
      step();
    end
    check("s1_done", {15'h0, done1_o}, 16'd1);
    check("s1_tt", {12'h0, tt1_o}, 16'b1110);
    wait_done(lat);
    step();

    // START re-pulsed mid-run with changed EXPECTED
    gate_sel = 0; EXPECTED = 4'b1000; START = 1'b1;
    step();
    ndone = 0; at = 0;
    for (int i = 1; i <= 24; i++) begin
      START = (i == 5);
      if (i == 5) EXPECTED = 4'b0001;
      step();
      if (done_o) begin ndone++; at = i; end
    end
    START = 1'b0;
    check("restart_ignored_count", 16'(ndone), 16'd1);
    check("restart_ignored_at", 16'(at), 16'd16);
    check("orig_expected_used", {14'h0, pass_o, fail_o}, 16'b10);

    // Async reset mid-run, then a clean run
    gate_sel = 3; EXPECTED = 4'b0111; START = 1'b1;
    step();
    START = 1'b0;
    repeat (8) step();
    #1 RST = 1'b1;
    #1 check("async_reset", {a_o, b_o, busy_o, done_o, tt_o, pass_o, fail_o, mism_o, 2'b00}, 16'h0);
    step();
    RST = 1'b0;
    step();
    run(3, 4'b0111, lat);
    check("after_reset_run", {10'h0, pass_o, fail_o, tt_o}, {10'h0, 2'b10, 4'b0111});
    step();

    // Y wrong during the hold of vector 11, right only on its sample edge
    gate_sel = 0; EXPECTED = 4'b1000; START = 1'b1;
    step();
    START = 1'b0;
    repeat (12) step();
    y_force_en = 1'b1; y_force_val = 1'b0;
    repeat (3) step();
    y_force_en = 1'b0;
    step();
    check("final_edge_sample", {10'h0, done_o, pass_o, tt_o}, {10'h0, 2'b11, 4'b1000});
    step();

    // START held continuously: back-to-back runs
    EXPECTED = 4'b1000; START = 1'b1;
    step();
    wait_done(lat);
    wait_done(gap);
    START = 1'b0;
    check("held_start_gap", 16'(gap), 16'd18);
    step(); step();

    // Randomized: random START, EXPECTED, gate, Y noise and occasional async reset
    for (int c = 0; c < 1500; c++) begin
      START = ($urandom_range(0, 7) == 0);
      EXPECTED = 4'($urandom);
      if ($urandom_range(0, 31) == 0) gate_sel = $urandom_range(0, 3);
      y_force_en = ($urandom_range(0, 3) == 0);
      y_force_val = 1'($urandom);
      if ($urandom_range(0, 199) == 0) begin
        RST = 1'b1;
        #1 RST = 1'b0;
      end
      step();
    end
    START = 1'b0; y_force_en = 1'b0;
    repeat (20) step();

    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
